// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl: write-back controller for the register file write port.
// Merges ALU results and in-order load returns onto one registered write port,
// tracks outstanding load destinations in a scoreboard and raises decode stall.
// Optional macro RF_WB_BYPASS_EN: releases the scoreboard one cycle earlier and
// adds rd1/rd2 forwarding ports that bypass the value currently on rf_wd.
module regfile_wb_ctrl #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = 5,
   parameter int unsigned DW    = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          alu_valid,
   input  logic [AW-1:0] alu_wa,
   input  logic [DW-1:0] alu_wd,
   input  logic          ld_issue_valid,
   input  logic [AW-1:0] ld_issue_wa,
   output logic          ld_issue_ready,
   input  logic          ld_ret_valid,
   input  logic [DW-1:0] ld_ret_wd,
   output logic          ld_ret_ready,
   input  logic [AW-1:0] chk_ra1,
   input  logic [AW-1:0] chk_ra2,
   input  logic [AW-1:0] chk_wa,
   output logic          stall,
`ifdef RF_WB_BYPASS_EN
   input  logic [DW-1:0] rd1_in,
   input  logic [DW-1:0] rd2_in,
   output logic [DW-1:0] rd1_fwd,
   output logic [DW-1:0] rd2_fwd,
`endif
   output logic          rf_we,
   output logic [AW-1:0] rf_wa,
   output logic [DW-1:0] rf_wd
);

   localparam int unsigned IW   = $clog2(DEPTH);
   localparam int unsigned PW   = IW + 1;
   localparam int unsigned NREG = 1 << AW;

   logic [AW-1:0]   tag_mem [DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic            fifo_full;
   logic            fifo_empty;
   logic [AW-1:0]   ret_wa;
   logic            ld_push;
   logic            ld_pop;

   logic [NREG-1:0] pending;
   logic            clr_en;
   logic [AW-1:0]   clr_wa;

   logic            skid_full;
   logic [AW-1:0]   skid_wa;
   logic [DW-1:0]   skid_wd;
   logic            skid_load;
   logic            skid_drain;

   logic            sel_any;
   logic            sel_load;
   logic            sel_we;
   logic [AW-1:0]   sel_wa;
   logic [DW-1:0]   sel_wd;

   logic            haz_ra1;
   logic            haz_ra2;
   logic            haz_wa;

   // FIFO status: extra pointer MSB distinguishes full from empty
   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                       (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]);
   assign ret_wa     = tag_mem[rd_ptr[IW-1:0]];

   // Handshakes: a second load to a pending register is held back
   assign ld_issue_ready = !fifo_full && !(pending[ld_issue_wa] && (ld_issue_wa != '0));
   assign ld_ret_ready   = !skid_full && !fifo_empty;
   assign ld_push        = ld_issue_valid && ld_issue_ready;
   assign ld_pop         = ld_ret_valid && ld_ret_ready;

   // Hazard detection against outstanding load destinations
   assign haz_ra1 = (chk_ra1 != '0) && pending[chk_ra1];
   assign haz_ra2 = (chk_ra2 != '0) && pending[chk_ra2];
   assign haz_wa  = (chk_wa  != '0) && pending[chk_wa];
   assign stall   = haz_ra1 || haz_ra2 || haz_wa || (ld_issue_valid && !ld_issue_ready);

   // Write-port source select: ALU, then skid, then direct load return
   always_comb begin
      sel_any    = 1'b0;
      sel_load   = 1'b0;
      sel_wa     = rf_wa;
      sel_wd     = rf_wd;
      skid_drain = 1'b0;
      if (alu_valid) begin
         sel_any = 1'b1;
         sel_wa  = alu_wa;
         sel_wd  = alu_wd;
      end else if (skid_full) begin
         sel_any    = 1'b1;
         sel_load   = 1'b1;
         sel_wa     = skid_wa;
         sel_wd     = skid_wd;
         skid_drain = 1'b1;
      end else if (ld_pop) begin
         sel_any  = 1'b1;
         sel_load = 1'b1;
         sel_wa   = ret_wa;
         sel_wd   = ld_ret_wd;
      end
   end

   // r0 writes consume their source but never reach the register file
   assign sel_we    = sel_any && (sel_wa != '0);
   assign skid_load = ld_pop && alu_valid;

`ifdef RF_WB_BYPASS_EN
   // Release the scoreboard as soon as the load data is launched onto rf_*
   assign clr_en = sel_load && sel_we;
   assign clr_wa = sel_wa;

   // Forward the in-flight write to decode reads of the same register
   assign rd1_fwd = (rf_we && (rf_wa == chk_ra1) && (chk_ra1 != '0)) ? rf_wd : rd1_in;
   assign rd2_fwd = (rf_we && (rf_wa == chk_ra2) && (chk_ra2 != '0)) ? rf_wd : rd2_in;
`else
   logic rf_ld;

   // Remember whether the current rf_* write is load data
   always_ff @(posedge clk) begin
      if (rst) rf_ld <= 1'b0;
      else     rf_ld <= sel_load && sel_we;
   end

   // Release the scoreboard once the register file has captured the load data
   assign clr_en = rf_we && rf_ld;
   assign clr_wa = rf_wa;
`endif

   // Tag storage; contents are meaningless while the FIFO is empty
   always_ff @(posedge clk) begin
      if (ld_push) tag_mem[wr_ptr[IW-1:0]] <= ld_issue_wa;
   end

   // FIFO pointers
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (ld_push) wr_ptr <= wr_ptr + PW'(1);
         if (ld_pop)  rd_ptr <= rd_ptr + PW'(1);
      end
   end

   // Pending-load scoreboard
   always_ff @(posedge clk) begin
      if (rst) begin
         pending <= '0;
      end else begin
         if (clr_en)                             pending[clr_wa]      <= 1'b0;
         if (ld_push && (ld_issue_wa != '0))     pending[ld_issue_wa] <= 1'b1;
      end
   end

   // Skid entry holds a load return that lost arbitration to the ALU
   always_ff @(posedge clk) begin
      if (rst) begin
         skid_full <= 1'b0;
         skid_wa   <= '0;
         skid_wd   <= '0;
      end else if (skid_load) begin
         skid_full <= 1'b1;
         skid_wa   <= ret_wa;
         skid_wd   <= ld_ret_wd;
      end else if (skid_drain) begin
         skid_full <= 1'b0;
      end
   end

   // Registered write port; address/data hold when nothing is written
   always_ff @(posedge clk) begin
      if (rst) begin
         rf_we <= 1'b0;
         rf_wa <= '0;
         rf_wd <= '0;
      end else begin
         rf_we <= sel_we;
         if (sel_we) begin
            rf_wa <= sel_wa;
            rf_wd <= sel_wd;
         end
      end
   end

endmodule
